multi_test_sender: RTL and testbench

MULTI_TEST_SENDER -- requirements
Module: multi_test_sender

---
 rtl/tp_pkg.sv | 32 +++
 rtl/tp_lane.sv | 63 ++++++
 rtl/multi_test_sender.sv | 137 +++++++++++++
 tb/tb_multi_test_sender.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tp_pkg.sv
// rtl/tp_pkg.sv - shared encodings, PRBS taps and seeds for the multi-lane test pattern sender
package tp_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK   = 2'd0,
    MODE_PRBS7   = 2'd1,
    MODE_PRBS15  = 2'd2,
    MODE_COUNTER = 2'd3
  } mode_t;

  localparam int PRBS7_TAP_HI  = 6;
  localparam int PRBS7_TAP_LO  = 5;
  localparam int PRBS15_TAP_HI = 14;
  localparam int PRBS15_TAP_LO = 13;

  localparam logic [6:0]  PRBS7_SEED  = 7'h7F;
  localparam logic [14:0] PRBS15_SEED = 15'h7FFF;

  // Fibonacci form: the MSB is the transmitted bit, the feedback enters at the LSB.
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
  endfunction

  function automatic logic [14:0] prbs15_next(input logic [14:0] s);
    return {s[13:0], s[PRBS15_TAP_HI] ^ s[PRBS15_TAP_LO]};
  endfunction

  function automatic logic is_prbs(input mode_t m);
    return (m == MODE_PRBS7) || (m == MODE_PRBS15);
  endfunction

endpackage

// File: rtl/tp_lane.sv
// rtl/tp_lane.sv - one serial lane: PRBS7/PRBS15 generators, frame shifter and MSB error inversion
module tp_lane
  import tp_pkg::*;
#(
  parameter int FRAME_W = 16,
  parameter int LANE    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               load,
  input  mode_t              bit_mode,
  input  logic               reseed,
  input  logic [FRAME_W-1:0] frame_word,
  input  logic               flip,
  output logic               serial
);

  localparam logic [6:0]  SEED7  = PRBS7_SEED ^ 7'(LANE);
  localparam logic [14:0] SEED15 = PRBS15_SEED ^ 15'(LANE);

  logic [6:0]         lfsr7;
  logic [14:0]        lfsr15;
  logic [FRAME_W-1:0] shreg;
  logic [6:0]         cur7;
  logic [14:0]        cur15;
  logic               bit_next;

  // A reseed takes effect on the very bit being emitted, so the seed MSB leads the frame.
  assign cur7  = (reseed && bit_mode == MODE_PRBS7)  ? SEED7  : lfsr7;
  assign cur15 = (reseed && bit_mode == MODE_PRBS15) ? SEED15 : lfsr15;

  always_comb begin
    bit_next = 1'b0;
    case (bit_mode)
      MODE_PRBS7:  bit_next = cur7[6];
      MODE_PRBS15: bit_next = cur15[14];
      default:     bit_next = load ? frame_word[FRAME_W-1] : shreg[FRAME_W-1];
    endcase
    bit_next = bit_next ^ flip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr7  <= SEED7;
      lfsr15 <= SEED15;
      shreg  <= '0;
      serial <= 1'b0;
    end else begin
      serial <= step ? bit_next : 1'b0;
      if (step) begin
        lfsr7  <= prbs7_next(cur7);
        lfsr15 <= prbs15_next(cur15);
      end
      if (load) begin
        shreg <= {frame_word[FRAME_W-2:0], 1'b0};
      end else if (step) begin
        shreg <= {shreg[FRAME_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/multi_test_sender.sv
// rtl/multi_test_sender.sv - multi-lane serial test pattern sender (clock, PRBS7, PRBS15, counter)
module multi_test_sender
  import tp_pkg::*;
#(
  parameter int                 NUM_CH    = 4,
  parameter int                 FRAME_W   = 16,
  parameter logic [FRAME_W-1:0] SYNC_WORD = FRAME_W'(16'hA5C3)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              inject_err,
  input  logic [NUM_CH-1:0] err_ch_mask,
  output logic [NUM_CH-1:0] serial_out,
  output logic              frame_start,
  output logic [1:0]        mode_active,
  output logic              err_done
);

  localparam int CNT_W = $clog2(FRAME_W);

  function automatic logic [FRAME_W-1:0] clock_pattern();
    logic [FRAME_W-1:0] w;
    for (int i = 0; i < FRAME_W; i++) begin
      w[i] = ((FRAME_W - 1 - i) % 2) == 0;
    end
    return w;
  endfunction

  localparam logic [FRAME_W-1:0] CLOCK_WORD = clock_pattern();

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  mode_t              mode_q;
  logic [FRAME_W-1:0] cnt_val;
  logic               cnt_odd;
  logic               armed;
  logic [NUM_CH-1:0]  arm_mask;

  mode_t              mode_req;
  logic               last_bit;
  logic               load;
  logic               step;
  logic               reseed;
  logic               counter_entry;
  mode_t              bit_mode;
  logic [FRAME_W-1:0] frame_word;

  assign mode_req      = mode_t'(mode);
  assign last_bit      = bit_cnt == CNT_W'(FRAME_W - 1);
  assign load          = en && (state == ST_IDLE || last_bit);
  assign step          = load || (state == ST_RUN && !last_bit);
  assign reseed        = load && is_prbs(mode_req) && (mode_req != mode_q);
  assign counter_entry = mode_q != MODE_COUNTER;
  assign bit_mode      = load ? mode_req : mode_q;
  assign mode_active   = mode_q;

  // Counter frames alternate sync/value; a fresh entry always opens with the sync word.
  always_comb begin
    frame_word = '0;
    case (mode_req)
      MODE_CLOCK:   frame_word = CLOCK_WORD;
      MODE_COUNTER: frame_word = (counter_entry || cnt_odd) ? SYNC_WORD : cnt_val;
      default:      frame_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      mode_q      <= MODE_CLOCK;
      cnt_val     <= '0;
      cnt_odd     <= 1'b0;
      armed       <= 1'b0;
      arm_mask    <= '0;
      frame_start <= 1'b0;
      err_done    <= 1'b0;
    end else begin
      frame_start <= load;
      err_done    <= load && armed;

      if (step) begin
        state   <= ST_RUN;
        bit_cnt <= load ? '0 : bit_cnt + CNT_W'(1);
      end else begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
      end

      if (load) begin
        mode_q <= mode_req;
        if (mode_req == MODE_COUNTER) begin
          if (counter_entry) begin
            cnt_odd <= 1'b0;
            cnt_val <= '0;
          end else if (!cnt_odd) begin
            cnt_odd <= 1'b1;
          end else begin
            cnt_odd <= 1'b0;
            cnt_val <= cnt_val + FRAME_W'(1);
          end
        end
      end

      // A pulse coinciding with consumption re-arms for the following frame.
      if (load && armed) begin
        armed <= inject_err;
        if (inject_err) arm_mask <= err_ch_mask;
      end else if (!armed && inject_err) begin
        armed    <= 1'b1;
        arm_mask <= err_ch_mask;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    tp_lane #(
      .FRAME_W (FRAME_W),
      .LANE    (i)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .step       (step),
      .load       (load),
      .bit_mode   (bit_mode),
      .reseed     (reseed),
      .frame_word (frame_word),
      .flip       (load && armed && arm_mask[i]),
      .serial     (serial_out[i])
    );
  end

endmodule

// File: tb/tb_multi_test_sender.sv
// tb/tb_multi_test_sender.sv - bench for multi_test_sender with a frame-level reference model
module tb_multi_test_sender;

  localparam int NUM_CH  = 4;
  localparam int FRAME_W = 16;
  localparam logic [15:0] SYNC = 16'hA5C3;

  logic              clk = 1'b0;
  logic              rst, en, inject_err;
  logic [1:0]        mode;
  logic [NUM_CH-1:0] err_ch_mask;
  logic [NUM_CH-1:0] serial_out;
  logic              frame_start, err_done;
  logic [1:0]        mode_active;

  always #5 clk = ~clk;

  multi_test_sender #(.NUM_CH(NUM_CH), .FRAME_W(FRAME_W), .SYNC_WORD(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .inject_err  (inject_err),
    .err_ch_mask (err_ch_mask),
    .serial_out  (serial_out),
    .frame_start (frame_start),
    .mode_active (mode_active),
    .err_done    (err_done)
  );

  int checks = 0;
  int failures = 0;

  bit seq7  [NUM_CH][127];
  bit seq15 [NUM_CH][32767];

  bit              m_run, m_armed;
  int              m_bit, m_mode, m_cframe, pos7, pos15;
  logic [NUM_CH-1:0] m_mask, m_flip;
  logic [15:0]     m_word;
  logic [NUM_CH-1:0] e_serial;
  logic            e_fs, e_ed;
  logic [1:0]      e_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level view: each frame is a mode chosen at its start plus a bit source,
  // PRBS streams are addressed by position since the last reseed.
  task automatic model_step();
    bit boundary;
    bit b;
    if (rst) begin
      m_run = 0; m_bit = 0; m_mode = 0; m_cframe = 0; m_armed = 0; m_mask = '0;
      pos7 = 0; pos15 = 0; e_serial = '0; e_fs = 0; e_ed = 0; e_mode = 2'd0;
      return;
    end
    boundary = !m_run || (m_bit == FRAME_W - 1);
    e_fs = 0; e_ed = 0; m_flip = '0;
    if (boundary && en) begin
      if (mode == 2'd1 && m_mode != 1) pos7 = 0;
      if (mode == 2'd2 && m_mode != 2) pos15 = 0;
      if (mode == 2'd3) begin
        if (m_mode != 3) m_cframe = 0; else m_cframe++;
        m_word = (m_cframe % 2 == 0) ? SYNC : 16'(m_cframe / 2);
      end else if (mode == 2'd0) begin
        m_word = 16'hAAAA;
      end
      m_mode = int'(mode); m_run = 1; m_bit = 0; e_fs = 1;
      if (m_armed) begin e_ed = 1; m_flip = m_mask; m_armed = 0; end
    end else if (boundary) begin
      m_run = 0;
    end else begin
      m_bit++;
    end
    if (inject_err && !m_armed) begin m_armed = 1; m_mask = err_ch_mask; end
    e_mode = 2'(m_mode);
    if (m_run) begin
      for (int l = 0; l < NUM_CH; l++) begin
        case (m_mode)
          1:       b = seq7[l][pos7 % 127];
          2:       b = seq15[l][pos15 % 32767];
          default: b = m_word[15 - m_bit];
        endcase
        e_serial[l] = b ^ m_flip[l];
      end
      pos7++; pos15++;
    end else begin
      e_serial = '0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("serial_out", 64'(serial_out), 64'(e_serial));
    chk("frame_start", 64'(frame_start), 64'(e_fs));
    chk("err_done", 64'(err_done), 64'(e_ed));
    chk("mode_active", 64'(mode_active), 64'(e_mode));
  endtask

  task automatic run_until_bit(input int b);
    int n;
    for (n = 0; n < 100 && !(m_run && m_bit == b); n++) cycle();
    checks++;
    assert (n < 100) else begin
      failures++;
      $error("FAIL wait_bit%0d observed=timeout expected=reached", b);
    end
  endtask

  task automatic pulse_err(input logic [NUM_CH-1:0] msk);
    inject_err = 1; err_ch_mask = msk;
    cycle();
    inject_err = 0;
  endtask

  logic [63:0] cap;
  bit          pr [254];
  int          ones, rep_bad;

  initial begin
    for (int l = 0; l < NUM_CH; l++) begin
      logic [6:0]  s7;
      logic [14:0] s15;
      s7 = 7'h7F ^ 7'(l);
      for (int i = 0; i < 127; i++) begin seq7[l][i] = s7[6]; s7 = {s7[5:0], s7[6] ^ s7[5]}; end
      s15 = 15'h7FFF ^ 15'(l);
      for (int i = 0; i < 32767; i++) begin seq15[l][i] = s15[14]; s15 = {s15[13:0], s15[14] ^ s15[13]}; end
    end

    rst = 1; en = 0; mode = 0; inject_err = 0; err_ch_mask = '0;
    cycle(); cycle();

    // counter mode from reset
    rst = 0; en = 1; mode = 2'd3;
    cap = '0;
    repeat (64) begin cycle(); cap = {cap[62:0], serial_out[0]}; end
    chk("counter_stream", cap, 64'hA5C3_0000_A5C3_0001);

    // PRBS7 for 254 cycles
    rst = 1; cycle(); rst = 0; mode = 2'd1;
    for (int i = 0; i < 254; i++) begin cycle(); pr[i] = serial_out[0]; end
    ones = 0; rep_bad = 0;
    for (int i = 0; i < 127; i++) begin ones += int'(pr[i]); if (pr[i] != pr[i + 127]) rep_bad++; end
    chk("prbs7_ones", 64'(ones), 64'd64);
    chk("prbs7_repeat", 64'(rep_bad), 64'd0);
    chk("prbs7_lead", {57'd0, pr[0], pr[1], pr[2], pr[3], pr[4], pr[5], pr[6]}, 64'h7F);

    // clock mode, switch to PRBS15 mid-frame
    rst = 1; cycle(); rst = 0; mode = 2'd0;
    run_until_bit(5);
    mode = 2'd2;
    repeat (40) cycle();

    // error injection: masked lanes, pulse while armed, re-arm on consumption, zero mask
    run_until_bit(6);
    pulse_err(4'b0101);
    run_until_bit(10);
    pulse_err(4'b1111);
    repeat (30) cycle();
    run_until_bit(4);
    pulse_err(4'b0010);
    run_until_bit(15);
    pulse_err(4'b1000);
    repeat (40) cycle();
    pulse_err(4'b0000);
    repeat (40) cycle();

    // en drop mid-frame with an armed error carried through IDLE, then reset mid-frame
    run_until_bit(3);
    en = 0;
    pulse_err(4'b0001);
    repeat (20) cycle();
    en = 1; mode = 2'd3;
    repeat (40) cycle();
    run_until_bit(8);
    rst = 1; cycle(); rst = 0;
    repeat (20) cycle();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      inject_err = ($urandom_range(0, 14) == 0);
      err_ch_mask = 4'($urandom_range(0, 15));
      cycle();
    end
    rst = 0; inject_err = 0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
